// File: rtl/control_sequencer.sv
// control_sequencer: T-state microsequencer for a small accumulator machine.
// A six-step ring counter (T1..T6) with a shared fetch (T1..T3) and an
// opcode-dependent execute phase (T4..T6). Every control output is a flop
// loaded with the decode of the *next* state, so outputs are glitch-free
// and depend only on registered tstate, latched opcode and halted.
module control_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_enable,
  output logic       mar_load,
  output logic       ram_enable,
  output logic       ir_load,
  output logic       ir_enable,
  output logic       a_load,
  output logic       a_enable,
  output logic       b_load,
  output logic       alu_enable,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] tstate
);

  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

  // Bit positions inside the packed control word.
  localparam int C_PC_INC  = 11;
  localparam int C_PC_EN   = 10;
  localparam int C_MAR_LD  = 9;
  localparam int C_RAM_EN  = 8;
  localparam int C_IR_LD   = 7;
  localparam int C_IR_EN   = 6;
  localparam int C_A_LD    = 5;
  localparam int C_A_EN    = 4;
  localparam int C_B_LD    = 3;
  localparam int C_ALU_EN  = 2;
  localparam int C_ALU_SUB = 1;
  localparam int C_OUT_LD  = 0;

  // Control word issued in T1; also the reset value of the output flops.
  localparam logic [11:0] CTRL_T1 = 12'b0110_0000_0000;

  tstate_e     tstate_q, tstate_d;
  logic        halted_q, halted_d;
  logic [3:0]  op_q, op_d;
  logic [11:0] ctrl_q, ctrl_d;

  // Control word for a given (tstate, opcode, halted); halted forces all-zero.
  function automatic logic [11:0] decode(input tstate_e t, input logic [3:0] op,
                                         input logic halt);
    logic [11:0] c;
    logic        mem_op;
    c      = 12'b0;
    mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    if (halt) begin
      c = 12'b0;
    end else begin
      case (t)
        T1: begin
          c[C_PC_EN]  = 1'b1;
          c[C_MAR_LD] = 1'b1;
        end
        T2: c[C_PC_INC] = 1'b1;
        T3: begin
          c[C_RAM_EN] = 1'b1;
          c[C_IR_LD]  = 1'b1;
        end
        T4: begin
          if (mem_op) begin
            c[C_IR_EN]  = 1'b1;
            c[C_MAR_LD] = 1'b1;
          end else if (op == OP_OUT) begin
            c[C_A_EN]   = 1'b1;
            c[C_OUT_LD] = 1'b1;
          end else begin
            c = 12'b0;
          end
        end
        T5: begin
          if (op == OP_LDA) begin
            c[C_RAM_EN] = 1'b1;
            c[C_A_LD]   = 1'b1;
          end else if ((op == OP_ADD) || (op == OP_SUB)) begin
            c[C_RAM_EN] = 1'b1;
            c[C_B_LD]   = 1'b1;
          end else begin
            c = 12'b0;
          end
        end
        T6: begin
          if ((op == OP_ADD) || (op == OP_SUB)) begin
            c[C_ALU_EN]  = 1'b1;
            c[C_A_LD]    = 1'b1;
            c[C_ALU_SUB] = (op == OP_SUB);
          end else begin
            c = 12'b0;
          end
        end
        default: c = 12'b0;
      endcase
    end
    return c;
  endfunction

  // Next T-state, halt flag and latched opcode, plus the matching control word.
  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    op_d     = op_q;
    if (run && !halted_q) begin
      case (tstate_q)
        T1: tstate_d = T2;
        T2: tstate_d = T3;
        T3: begin
          tstate_d = T4;
          op_d     = opcode;
        end
        T4: begin
          if (op_q == OP_HLT) begin
            tstate_d = T4;
            halted_d = 1'b1;
          end else begin
            tstate_d = T5;
          end
        end
        T5: tstate_d = T6;
        T6: tstate_d = T1;
        default: tstate_d = T1;
      endcase
    end else begin
      tstate_d = tstate_q;
    end
    ctrl_d = decode(tstate_d, op_d, halted_d);
  end

  // Sequencer state and registered control outputs with async reset to T1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tstate_q <= T1;
      halted_q <= 1'b0;
      op_q     <= 4'h0;
      ctrl_q   <= CTRL_T1;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
      op_q     <= op_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign pc_inc     = ctrl_q[C_PC_INC];
  assign pc_enable  = ctrl_q[C_PC_EN];
  assign mar_load   = ctrl_q[C_MAR_LD];
  assign ram_enable = ctrl_q[C_RAM_EN];
  assign ir_load    = ctrl_q[C_IR_LD];
  assign ir_enable  = ctrl_q[C_IR_EN];
  assign a_load     = ctrl_q[C_A_LD];
  assign a_enable   = ctrl_q[C_A_EN];
  assign b_load     = ctrl_q[C_B_LD];
  assign alu_enable = ctrl_q[C_ALU_EN];
  assign alu_sub    = ctrl_q[C_ALU_SUB];
  assign out_load   = ctrl_q[C_OUT_LD];
  assign halted     = halted_q;
  assign tstate     = tstate_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-vector bench for control_sequencer.
// Control outputs are packed as {pc_inc, pc_enable, mar_load, ram_enable,
// ir_load, ir_enable, a_load, a_enable, b_load, alu_enable, alu_sub, out_load}
// and compared to hand-written constants once per cycle on the falling edge.
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] opcode;
  logic       pc_inc, pc_enable, mar_load, ram_enable, ir_load, ir_enable;
  logic       a_load, a_enable, b_load, alu_enable, alu_sub, out_load;
  logic       halted;
  logic [2:0] tstate;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [11:0] C_T1     = 12'b0110_0000_0000;
  localparam logic [11:0] C_T2     = 12'b1000_0000_0000;
  localparam logic [11:0] C_T3     = 12'b0001_1000_0000;
  localparam logic [11:0] C_MEM4   = 12'b0010_0100_0000;
  localparam logic [11:0] C_LDA5   = 12'b0001_0010_0000;
  localparam logic [11:0] C_ADD5   = 12'b0001_0000_1000;
  localparam logic [11:0] C_ADD6   = 12'b0000_0010_0100;
  localparam logic [11:0] C_SUB6   = 12'b0000_0010_0110;
  localparam logic [11:0] C_OUT4   = 12'b0000_0001_0001;
  localparam logic [11:0] C_NONE   = 12'b0000_0000_0000;

  control_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .pc_inc     (pc_inc),
    .pc_enable  (pc_enable),
    .mar_load   (mar_load),
    .ram_enable (ram_enable),
    .ir_load    (ir_load),
    .ir_enable  (ir_enable),
    .a_load     (a_load),
    .a_enable   (a_enable),
    .b_load     (b_load),
    .alu_enable (alu_enable),
    .alu_sub    (alu_sub),
    .out_load   (out_load),
    .halted     (halted),
    .tstate     (tstate)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] ctl();
    return {pc_inc, pc_enable, mar_load, ram_enable, ir_load, ir_enable,
            a_load, a_enable, b_load, alu_enable, alu_sub, out_load};
  endfunction

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // At most one bus driver in any cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check("bus_drivers",
            16'(int'(pc_enable) + int'(ram_enable) + int'(ir_enable) +
                int'(a_enable) + int'(alu_enable) <= 1),
            16'd1);
    end
  end

  task automatic expect_step(input logic [2:0] t, input logic [11:0] c,
                             input logic h, input string tag);
    @(negedge clk);
    check({tag, "_tstate"}, 16'(tstate), 16'(t));
    check({tag, "_ctl"},    16'(ctl()),  16'(c));
    check({tag, "_halted"}, 16'(halted), 16'(h));
  endtask

  // Asynchronous reset pulse placed mid-cycle; checked before any clock edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_rst_tstate"}, 16'(tstate), 16'd1);
    check({tag, "_rst_ctl"},    16'(ctl()),  16'(C_T1));
    check({tag, "_rst_halted"}, 16'(halted), 16'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full instruction starting from T1; optional stall and late opcode change in T5.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] op_late,
                           input logic [11:0] e4, input logic [11:0] e5,
                           input logic [11:0] e6, input int stall, input string tag);
    opcode = op;
    expect_step(3'd2, C_T2, 1'b0, tag);
    expect_step(3'd3, C_T3, 1'b0, tag);
    expect_step(3'd4, e4,   1'b0, tag);
    expect_step(3'd5, e5,   1'b0, tag);
    opcode = op_late;
    if (stall > 0) begin
      run = 1'b0;
      repeat (stall) expect_step(3'd5, e5, 1'b0, {tag, "_stall"});
      run = 1'b1;
    end
    expect_step(3'd6, e6,   1'b0, tag);
    expect_step(3'd1, C_T1, 1'b0, tag);
  endtask

  initial begin
    reset  = 1'b0;
    run    = 1'b0;
    opcode = 4'h0;
    run    = 1'b1;
    do_reset("init");

    run_instr(4'h0, 4'h0, C_MEM4, C_LDA5, C_NONE, 0, "lda");
    run_instr(4'h2, 4'h1, C_MEM4, C_ADD5, C_SUB6, 0, "sub_late_add");
    run_instr(4'hE, 4'hE, C_OUT4, C_NONE, C_NONE, 0, "out");
    run_instr(4'h7, 4'h7, C_NONE, C_NONE, C_NONE, 0, "nop7");
    run_instr(4'h1, 4'h1, C_MEM4, C_ADD5, C_ADD6, 3, "add_stall");

    // HLT: freeze at T4 with all controls low, whatever run/opcode do.
    opcode = 4'hF;
    expect_step(3'd2, C_T2,   1'b0, "hlt");
    expect_step(3'd3, C_T3,   1'b0, "hlt");
    expect_step(3'd4, C_NONE, 1'b0, "hlt");
    for (int i = 0; i < 10; i++) begin
      opcode = 4'(i);
      run    = (i < 3 || i > 5);
      expect_step(3'd4, C_NONE, 1'b1, "halted");
    end
    run = 1'b1;
    do_reset("hlt");

    // SUB interrupted by reset during T6.
    opcode = 4'h2;
    expect_step(3'd2, C_T2,   1'b0, "sub_rst");
    expect_step(3'd3, C_T3,   1'b0, "sub_rst");
    expect_step(3'd4, C_MEM4, 1'b0, "sub_rst");
    expect_step(3'd5, C_ADD5, 1'b0, "sub_rst");
    expect_step(3'd6, C_SUB6, 1'b0, "sub_rst");
    do_reset("sub_t6");

    run_instr(4'h7, 4'h3, C_NONE, C_NONE, C_NONE, 0, "nop_after_rst");
    run_instr(4'h0, 4'h0, C_MEM4, C_LDA5, C_NONE, 0, "lda2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
